// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op at a time, drives the result mux select,
// starts/awaits multi-cycle units with timeout and returns the captured result.
module alu_op_sequencer #(
    parameter int W        = 64,
    parameter int MAX_WAIT = 64,
    parameter int CW       = 7
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] opa,
    output logic [W-1:0] opb,
    output logic [3:0]   alu_sel,
    output logic [3:0]   unit_start,
    input  logic [3:0]   unit_done,
    input  logic [W-1:0] mux_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_op,
    output logic         rsp_err
);
    typedef enum logic [2:0] {IDLE, EXEC, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [3:0]     sel_q, sel_d, op_q, op_d, start_q, start_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done;

    // multi-cycle ops are 12..15, so the unit index is the low two select bits
    assign done = unit_done[sel_q[1:0]];

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sel_d   = sel_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        start_d = 4'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                opa_d   = req_a;
                opb_d   = req_b;
                sel_d   = req_op;
                op_d    = req_op;
                state_d = (req_op < 4'd12) ? EXEC : ISSUE;
                start_d = (req_op < 4'd12) ? 4'b0 : 4'b1 << req_op[1:0];
            end
            EXEC: begin
                res_d   = mux_out;
                err_d   = 1'b0;
                state_d = RESP;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (done) begin
                res_d   = mux_out;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sel_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign opa        = opa_q;
    assign opb        = opb_q;
    assign alu_sel    = sel_q;
    assign unit_start = start_q;
    assign rsp_result = res_q;
    assign rsp_op     = op_q;
    assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random + directed requests against a transaction-level
// model; a monitor scores responses, latency, start pulses and hold behaviour.
module tb_alu_op_sequencer;
    localparam int W  = 64;
    localparam int MW = 8;

    logic         clk = 1'b0, rst_b, req_valid = 1'b0, req_ready;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [3:0]   req_op = '0, alu_sel, unit_start, unit_done, rsp_op;
    logic [W-1:0] req_a = '0, req_b = '0, opa, opb, mux_out, rsp_result;
    logic [3:0]   pulse = '0, noise = '0, force_noise = '0, mask = '0;
    logic         hold = 1'b0, noise_en = 1'b0, unit_busy = 1'b0;
    int           cur_l = 0;
    int           errors = 0, checks = 0, cyc = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   op;
        logic         err;
        int           lat;
    } exp_t;
    exp_t sbq[$];

    alu_op_sequencer #(.W(W), .MAX_WAIT(MW), .CW(7)) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .opa(opa), .opb(opb),
        .alu_sel(alu_sel), .unit_start(unit_start), .unit_done(unit_done),
        .mux_out(mux_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mux_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0, 4'd3:  return a + b;
            4'd1:        return a - b;
            4'd2:        return a & b;
            4'd4:        return a | b;
            4'd5, 4'd13: return a ^ b;
            4'd6:        return a << b[5:0];
            4'd7:        return a >> b[5:0];
            4'd12:       return a * b;
            4'd14:       return b - a;
            default:     return ~a ^ {b[31:0], 28'd0, op};
        endcase
    endfunction

    // multi-cycle results are only meaningful on the mux while the unit signals done
    assign unit_done = pulse | (noise & ~mask);
    assign mux_out = (alu_sel >= 4'd12 && (pulse & (4'b1 << alu_sel[1:0])) == 4'b0)
                     ? 64'hBAD0_BAD0_BAD0_BAD0 : mux_f(alu_sel, opa, opb);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int l, input bit push);
        exp_t e;
        int t;
        if (errors > 20) return;
        t = 0;
        while (unit_busy && t < 300) begin @(posedge clk); t++; end
        if (unit_busy) begin tmo("unit_idle"); return; end
        e.op = op; e.err = 1'b0; e.res = mux_f(op, a, b); e.lat = 1;
        if (op >= 4'd12) begin
            if (l >= 1 && l <= MW) e.lat = l + 1;
            else begin e.lat = MW + 1; e.res = '0; e.err = 1'b1; end
            cur_l = l;
            mask = 4'b1 << op[1:0];
            unit_busy = 1'b1;
        end
        if (push) sbq.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 300) begin @(negedge clk); t++; end
        if (!req_ready) tmo("accept");
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin @(posedge clk); t++; end
        check("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic check_reset();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_unit_start", 64'(unit_start), 64'd0);
        check("rst_alu_sel", 64'(alu_sel), 64'd0);
        check("rst_opa", opa, 64'd0);
        check("rst_opb", opb, 64'd0);
        check("rst_result", rsp_result, 64'd0);
        check("rst_op", 64'(rsp_op), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        noise = noise_en ? 4'($urandom) : force_noise;
    end

    initial begin : unit_model
        int l;
        logic [3:0] bm;
        forever begin
            @(negedge clk);
            if (unit_start != 4'b0) begin
                l = cur_l;
                bm = unit_start;
                if (l > 0) begin
                    repeat (l) @(posedge clk);
                    #1 pulse = bm;
                    @(posedge clk);
                    #1 pulse = 4'b0;
                end else begin
                    repeat (MW + 2) @(posedge clk);
                    #1;
                end
                mask = 4'b0;
                unit_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        int acc_edge;
        logic [3:0] acc_op;
        logic [W-1:0] acc_a, acc_b, p_res;
        logic [3:0] p_op;
        logic have_acc, pv, pr, p_err;
        exp_t e;
        acc_edge = -100; acc_op = '0; acc_a = '0; acc_b = '0; have_acc = 1'b0;
        pv = 1'b0; pr = 1'b0; p_res = '0; p_op = '0; p_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                have_acc = 1'b0; acc_edge = -100; pv = 1'b0; pr = 1'b0;
            end else begin
                check("unit_start", 64'(unit_start),
                      64'((cyc == acc_edge && acc_op >= 4'd12) ? 4'b1 << acc_op[1:0] : 4'b0));
                if (have_acc) begin
                    check("alu_sel", 64'(alu_sel), 64'(acc_op));
                    check("opa", opa, acc_a);
                    check("opb", opb, acc_b);
                end
                check("ready_while_valid", 64'(req_ready & rsp_valid), 64'd0);
                if (pv && !pr) begin
                    check("hold_valid", 64'(rsp_valid), 64'd1);
                    check("hold_result", rsp_result, p_res);
                    check("hold_op", 64'(rsp_op), 64'(p_op));
                    check("hold_err", 64'(rsp_err), 64'(p_err));
                end
                if (rsp_valid && !pv) begin
                    if (sbq.size() == 0) tmo("unexpected_rsp");
                    else check("latency", 64'(cyc - acc_edge), 64'(sbq[0].lat));
                end
                if (rsp_valid && rsp_ready && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_op", 64'(rsp_op), 64'(e.op));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                if (req_valid && req_ready) begin
                    acc_edge = cyc + 1; acc_op = req_op; acc_a = req_a; acc_b = req_b; have_acc = 1'b1;
                end
                pv = rsp_valid; pr = rsp_ready; p_res = rsp_result; p_op = rsp_op; p_err = rsp_err;
            end
        end
    end

    initial begin : stimulus
        int t;
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        #11 check_reset();
        @(negedge clk); #2 rst_b = 1'b1;
        repeat (2) @(posedge clk);
        issue(4'd3, 64'h5, 64'h7, 0, 1'b1);
        issue(4'd13, 64'hDEAD_BEEF, 64'h0, 5, 1'b1);
        drain();
        hold = 1'b1;
        issue(4'd5, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1'b1);
        fork
            issue(4'd1, 64'h100, 64'h1, 0, 1'b1);
            begin
                t = 0;
                while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
                if (!rsp_valid) tmo("bp_valid");
                repeat (10) @(negedge clk);
                #2 hold = 1'b0;
            end
        join
        issue(4'd15, 64'hAA, 64'h55, MW + 3, 1'b1);
        issue(4'd15, 64'h1, 64'h2, 0, 1'b1);
        issue(4'd14, 64'h3, 64'h9, MW, 1'b1);
        issue(4'd14, 64'h3, 64'h9, MW + 1, 1'b1);
        issue(4'd12, 64'h6, 64'h7, 1, 1'b1);
        force_noise = 4'b1110;
        issue(4'd12, 64'h11, 64'h13, 6, 1'b1);
        drain();
        force_noise = 4'b0;
        noise_en = 1'b1;
        for (int i = 0; i < 150; i++)
            issue(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, MW + 3), 1'b1);
        drain();
        issue(4'd14, 64'h77, 64'h99, 12, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_b = 1'b0;
        #1 check_reset();
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b1;
        #1 check("post_rst_ready", 64'(req_ready), 64'd1);
        issue(4'd2, 64'hF0F0, 64'hFF00, 0, 1'b1);
        issue(4'd13, 64'hC0FFEE, 64'h1, 3, 1'b1);
        drain();
        noise_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
